// File: rtl/conv_pkg.sv
// Shared defaults, derived frame geometry and FSM encodings for the conv output streamer.
package conv_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_H          = 8;
    localparam int unsigned DEF_W          = 8;
    localparam int unsigned DEF_F          = 3;
    localparam int unsigned DEF_K          = 6;

    localparam int unsigned DEF_OH   = DEF_H - DEF_F + 1;
    localparam int unsigned DEF_OW   = DEF_W - DEF_F + 1;
    localparam int unsigned DEF_NPIX = DEF_K * DEF_OH * DEF_OW;

    // Streamer FSM encoding
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Index width that never collapses to zero bits
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_output_streamer_if.sv
// Valid/ready element stream carrying one feature-map element plus its position flags.
interface conv_output_streamer_if #(
    parameter int unsigned DATA_WIDTH = conv_pkg::DEF_DATA_WIDTH,
    parameter int unsigned MW         = conv_pkg::idx_width(conv_pkg::DEF_K)
);

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [MW-1:0]         out_map_idx;
    logic                  out_last_row;
    logic                  out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_map_idx,
        output out_last_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_map_idx,
        input  out_last_row,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/conv_stream_counter.sv
// Nested column/row/map position counter for the streamed feature maps.
module conv_stream_counter
    import conv_pkg::*;
#(
    parameter int unsigned OH = DEF_OH,
    parameter int unsigned OW = DEF_OW,
    parameter int unsigned K  = DEF_K,
    parameter int unsigned MW = idx_width(DEF_K)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      advance,
    output logic [idx_width(OW)-1:0]  col,
    output logic [idx_width(OH)-1:0]  row,
    output logic [MW-1:0]             map,
    output logic                      last_row,
    output logic                      last
);

    localparam int unsigned CW = idx_width(OW);
    localparam int unsigned RW = idx_width(OH);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [MW-1:0] map_q, map_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            map_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            map_q <= map_d;
        end
    end

    // Clear wins over advance so a new frame always starts at element 0
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        map_d = map_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
            map_d = '0;
        end else if (advance) begin
            if (col_q == CW'(OW - 1)) begin
                col_d = '0;
                if (row_q == RW'(OH - 1)) begin
                    row_d = '0;
                    map_d = (map_q == MW'(K - 1)) ? '0 : map_q + MW'(1);
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    assign col      = col_q;
    assign row      = row_q;
    assign map      = map_q;
    assign last_row = (col_q == CW'(OW - 1));
    assign last     = last_row && (row_q == RW'(OH - 1)) && (map_q == MW'(K - 1));

endmodule

// File: rtl/conv_output_streamer.sv
// Captures a frame of K convolution output maps and streams it element by element
// over a valid/ready interface, map-major then row then column.
module conv_output_streamer
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned H          = DEF_H,
    parameter int unsigned W          = DEF_W,
    parameter int unsigned F          = DEF_F,
    parameter int unsigned K          = DEF_K
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             done,
    input  logic [0:K*(H-F+1)*(W-F+1)*DATA_WIDTH-1]          feature_maps,
    input  logic                                             overrun_clr,
    output logic                                             busy,
    output logic                                             overrun,
    conv_output_streamer_if.master                           out_if
);

    localparam int unsigned OH   = H - F + 1;
    localparam int unsigned OW   = W - F + 1;
    localparam int unsigned NPIX = K * OH * OW;
    localparam int unsigned MW   = idx_width(K);
    localparam int unsigned CW   = idx_width(OW);
    localparam int unsigned RW   = idx_width(OH);
    localparam int unsigned BW   = NPIX * DATA_WIDTH;

    logic [0:0]    state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [BW-1:0] frame_in;
    logic          overrun_q, overrun_d;
    logic          cnt_clear;
    logic          cnt_advance;
    logic [CW-1:0] cnt_col;
    logic [RW-1:0] cnt_row;
    logic [MW-1:0] cnt_map;
    logic          cnt_last_row;
    logic          cnt_last;
    logic          cnt_unused;
    logic          xfer;

    conv_stream_counter #(
        .OH (OH),
        .OW (OW),
        .K  (K),
        .MW (MW)
    ) u_counter (
        .clk      (clk),
        .rst_n    (reset),
        .clear    (cnt_clear),
        .advance  (cnt_advance),
        .col      (cnt_col),
        .row      (cnt_row),
        .map      (cnt_map),
        .last_row (cnt_last_row),
        .last     (cnt_last)
    );

    // Column/row are available for debug probing; only the derived flags drive outputs
    assign cnt_unused = ^{cnt_col, cnt_row};

    // Repack so element 0 sits at the low end of the shift buffer
    always_comb begin
        frame_in = '0;
        for (int unsigned e = 0; e < NPIX; e++) begin
            frame_in[e*DATA_WIDTH +: DATA_WIDTH] = feature_maps[e*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign xfer = (state_q == ST_STREAM) && out_if.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            overrun_q <= overrun_d;
        end
    end

    // Buffer shifts down one element per transfer; the head is always the element on the bus
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        overrun_d   = overrun_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;

        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (done) begin
                    buf_d     = frame_in;
                    cnt_clear = 1'b1;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    cnt_advance = 1'b1;
                    buf_d       = buf_q >> DATA_WIDTH;
                end
                if (xfer && cnt_last) begin
                    if (done) begin
                        buf_d     = frame_in;
                        cnt_clear = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (done) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_if.out_data     = buf_q[DATA_WIDTH-1:0];
    assign out_if.out_valid    = (state_q == ST_STREAM);
    assign out_if.out_map_idx  = cnt_map;
    assign out_if.out_last_row = (state_q == ST_STREAM) && cnt_last_row;
    assign out_if.out_last     = (state_q == ST_STREAM) && cnt_last;
    assign busy                = (state_q == ST_STREAM);
    assign overrun             = overrun_q;

endmodule

// File: tb/tb_conv_output_streamer.sv
// Scoreboard bench for conv_output_streamer: frames are modelled on load and
// checked beat by beat as the DUT streams them.
module tb_conv_output_streamer;

    localparam int unsigned DW   = 8;
    localparam int unsigned NPIX = 216;
    localparam int unsigned MW   = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [MW-1:0] map;
        logic          last_row;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              done;
    logic              overrun_clr;
    logic              busy;
    logic              overrun;
    logic [0:NPIX*DW-1] fm;

    beat_t exp_q[$];
    int    n_tests    = 0;
    int    n_fail     = 0;
    int    beats_seen = 0;

    always #5 clk = ~clk;

    conv_output_streamer_if #(.DATA_WIDTH(DW), .MW(MW)) sif ();

    conv_output_streamer #(
        .DATA_WIDTH (DW),
        .H          (8),
        .W          (8),
        .F          (3),
        .K          (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .done         (done),
        .feature_maps (fm),
        .overrun_clr  (overrun_clr),
        .busy         (busy),
        .overrun      (overrun),
        .out_if       (sif.master)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_frame(input int seed);
        for (int e = 0; e < NPIX; e++) begin
            fm[e*DW +: DW] = DW'((e + seed) % 256);
        end
    endtask

    task automatic push_frame(input int seed);
        beat_t b;
        for (int e = 0; e < NPIX; e++) begin
            b.data     = DW'((e + seed) % 256);
            b.map      = MW'(e / 36);
            b.last_row = ((e % 6) == 5);
            b.last     = (e == NPIX - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_frame(input int seed);
        set_frame(seed);
        push_frame(seed);
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic wait_beats(input int target, input string tag, output int cycles);
        cycles = 0;
        while (beats_seen != target && cycles < 5000) begin
            step();
            cycles++;
        end
        check_eq(tag, 32'(beats_seen), 32'(target));
    endtask

    // Beats are judged mid-cycle against the model head; the head is only consumed on a transfer
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (sif.out_valid === 1'b1) begin
                check_eq($sformatf("beat_avail@%0d", beats_seen), 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    check_eq($sformatf("data@%0d", beats_seen), 32'(sif.out_data), 32'(exp_q[0].data));
                    check_eq($sformatf("map@%0d", beats_seen), 32'(sif.out_map_idx), 32'(exp_q[0].map));
                    check_eq($sformatf("last_row@%0d", beats_seen), 32'(sif.out_last_row), 32'(exp_q[0].last_row));
                    check_eq($sformatf("last@%0d", beats_seen), 32'(sif.out_last), 32'(exp_q[0].last));
                    if (sif.out_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                        beats_seen++;
                    end
                end
            end else begin
                check_eq("idle_last_row", 32'(sif.out_last_row), 32'(0));
                check_eq("idle_last", 32'(sif.out_last), 32'(0));
            end
        end
    end

    initial begin
        int          base;
        int          cyc;
        logic [3:0]  pat;

        pat           = 4'b1001;
        reset         = 1'b1;
        done          = 1'b0;
        overrun_clr   = 1'b0;
        sif.out_ready = 1'b1;
        fm            = '0;

        #3 reset = 1'b0;
        #1;
        check_eq("rst_valid", 32'(sif.out_valid), 32'(0));
        check_eq("rst_data", 32'(sif.out_data), 32'(0));
        check_eq("rst_map", 32'(sif.out_map_idx), 32'(0));
        check_eq("rst_last_row", 32'(sif.out_last_row), 32'(0));
        check_eq("rst_last", 32'(sif.out_last), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_overrun", 32'(overrun), 32'(0));
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();

        // Full-rate frame
        base = beats_seen;
        start_frame(0);
        check_eq("t1_lat_valid", 32'(sif.out_valid), 32'(1));
        check_eq("t1_busy", 32'(busy), 32'(1));
        wait_beats(base + 216, "t1_beats", cyc);
        check_eq("t1_cycles", 32'(cyc), 32'(216));
        check_eq("t1_end_valid", 32'(sif.out_valid), 32'(0));
        check_eq("t1_end_busy", 32'(busy), 32'(0));

        // Backpressure 1,0,0,1
        step();
        base = beats_seen;
        start_frame(0);
        cyc = 0;
        while (beats_seen != base + 216 && cyc < 5000) begin
            sif.out_ready = pat[cyc % 4];
            step();
            cyc++;
        end
        sif.out_ready = 1'b1;
        check_eq("t2_beats", 32'(beats_seen), 32'(base + 216));
        check_eq("t2_cycles", 32'(cyc), 32'(432));
        check_eq("t2_end_valid", 32'(sif.out_valid), 32'(0));

        // done mid-frame with a set/clear collision, then a clean clear
        step();
        base = beats_seen;
        start_frame(0);
        wait_beats(base + 100, "t3_b100", cyc);
        set_frame(50);
        done        = 1'b1;
        overrun_clr = 1'b1;
        step();
        done        = 1'b0;
        overrun_clr = 1'b0;
        check_eq("t3_overrun_set", 32'(overrun), 32'(1));
        check_eq("t3_busy", 32'(busy), 32'(1));
        wait_beats(base + 216, "t3_beats", cyc);
        check_eq("t3_end_valid", 32'(sif.out_valid), 32'(0));
        check_eq("t3_overrun_sticky", 32'(overrun), 32'(1));
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check_eq("t3_overrun_clr", 32'(overrun), 32'(0));

        // Back-to-back frames: done on the final transfer
        step();
        base = beats_seen;
        start_frame(0);
        wait_beats(base + 215, "t4_b215", cyc);
        set_frame(77);
        push_frame(77);
        done = 1'b1;
        step();
        done = 1'b0;
        check_eq("t4_b2b_valid", 32'(sif.out_valid), 32'(1));
        check_eq("t4_b2b_overrun", 32'(overrun), 32'(0));
        check_eq("t4_a_done", 32'(beats_seen), 32'(base + 216));
        wait_beats(base + 432, "t4_beats", cyc);
        check_eq("t4_end_valid", 32'(sif.out_valid), 32'(0));

        // Reset during beat 50 discards the frame
        step();
        base = beats_seen;
        start_frame(0);
        wait_beats(base + 50, "t5_b50", cyc);
        #1 reset = 1'b0;
        #1;
        check_eq("t5_rst_valid", 32'(sif.out_valid), 32'(0));
        check_eq("t5_rst_data", 32'(sif.out_data), 32'(0));
        check_eq("t5_rst_map", 32'(sif.out_map_idx), 32'(0));
        check_eq("t5_rst_last", 32'(sif.out_last), 32'(0));
        check_eq("t5_rst_busy", 32'(busy), 32'(0));
        exp_q.delete();
        repeat (2) step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq($sformatf("t5_quiet%0d", i), 32'(sif.out_valid), 32'(0));
        end
        base = beats_seen;
        start_frame(200);
        check_eq("t5_new_valid", 32'(sif.out_valid), 32'(1));
        wait_beats(base + 216, "t5_beats", cyc);
        check_eq("t5_end_valid", 32'(sif.out_valid), 32'(0));

        step();
        check_eq("q_empty", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_output_streamer.md
CONV_OUTPUT_STREAMER -- requirements
Module: conv_output_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per feature-map element.
REQ-002 Parameter H, default 8: input image height.
REQ-003 Parameter W, default 8: input image width.
REQ-004 Parameter F, default 3: filter size.
REQ-005 Parameter K, default 6: number of feature maps per frame.
REQ-006 Derived constants SHALL be OH=H-F+1, OW=W-F+1, NPIX=K*OH*OW, MW=max(1,clog2(K)).
REQ-007 Clock and reset SHALL be exactly as decided: one clock; reset is asynchronous and active-low.
  - clk  input  1  rising-edge clock.
  - reset  input  1  asynchronous, active-low reset.
REQ-008 Remaining ports:
  - done  input  1  one-cycle pulse: feature_maps is valid this cycle.
  - feature_maps  input  [0:NPIX*DATA_WIDTH-1]  flat K maps; element e occupies bits [e*DATA_WIDTH +: DATA_WIDTH].
  - out_ready  input  1  downstream can accept.
  - overrun_clr  input  1  clears overrun.
  - out_data  output  DATA_WIDTH  current element.
  - out_valid  output  1  out_data valid.
  - out_map_idx  output  MW  map index of current element.
  - out_last_row  output  1  element is last column of a row.
  - out_last  output  1  element is last of frame.
  - busy  output  1  frame held or streaming.
  - overrun  output  1  sticky: done arrived while busy.

Function
REQ-009 FSM states SHALL be IDLE and STREAM only.
REQ-010 In IDLE, done=1 SHALL capture feature_maps into an internal NPIX-element buffer, zero counters, and enter STREAM; out_valid=1 on the next cycle (latency 1).
REQ-011 Element order SHALL be map-major, then row, then column; element e=map*OH*OW+row*OW+col is streamed at position e.
REQ-012 A transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1; only then do counters advance.
REQ-013 While out_valid=1 and out_ready=0, out_data, out_map_idx, out_last_row, out_last SHALL hold stable.
REQ-014 Counters: col wraps OW-1->0 and increments row; row wraps OH-1->0 and increments map.
REQ-015 out_last_row SHALL equal (col==OW-1); out_last SHALL equal (map==K-1 && row==OH-1 && col==OW-1); both qualified by out_valid.
REQ-016 Transfer of the out_last element SHALL return the FSM to IDLE; out_valid=0 the next cycle.
REQ-017 done coinciding with the out_last transfer SHALL capture the new frame and remain in STREAM with element 0 valid next cycle; overrun not set.
REQ-018 done in STREAM at any other cycle SHALL be ignored (buffer unchanged) and set overrun.
REQ-019 overrun_clr=1 SHALL clear overrun next cycle; simultaneous set and clear SHALL leave overrun=1.
REQ-020 busy SHALL equal (state==STREAM).
REQ-021 Throughput SHALL be one element per cycle with out_ready held high: NPIX consecutive valid cycles per frame.

Reset
REQ-022 reset=0 SHALL force IDLE, counters 0, buffer 0, out_valid 0, out_data 0, out_map_idx 0, out_last_row 0, out_last 0, busy 0, overrun 0, immediately and independent of clk.
REQ-023 Reset asserted mid-frame SHALL discard the frame; after release the block waits for a new done.

Structure
REQ-024 Shared package conv_pkg SHALL hold default DATA_WIDTH/H/W/F/K, derived OH/OW/NPIX, and the state enumeration.
REQ-025 Nested col/row/map counting SHALL live in one sub-module conv_stream_counter (inputs: clear, advance; outputs: col, row, map, last_row, last).

Verification
REQ-026 Reset, then done with element e = e mod 256, out_ready=1 -> 216 consecutive beats 0..215 mod 256, out_last only on beat 215, out_last_row on beats 5,11,...,215.
REQ-027 Same frame, out_ready toggling 1,0,0,1 -> all 216 beats in order, outputs stable during every stall cycle, no loss or duplication.
REQ-028 done on beat 100 of frame A (data B) -> frame A completes unchanged, overrun=1; overrun_clr pulse -> overrun=0 next cycle.
REQ-029 done with frame B on the out_last transfer of frame A -> beat 0 of B valid next cycle, no gap, overrun=0.
REQ-030 reset=0 during beat 50 -> out_valid=0 immediately; after release no output until next done; next frame streams from beat 0.
REQ-031 out_map_idx check: beats 0-35 -> 0, 36-71 -> 1, ..., 180-215 -> 5.
